task_stream_uart_tx: RTL and testbench

Output-side bridge between a task block and the UART pin. It accepts the task's unthrottled byte stream (data/valid/last), buffers it in a FIFO and serializes each byte as an 8N1 UART frame on the TX line. It flags frame boundaries and buffer overflow. It sits between any `task_NN` output and the board's TX pin, mirroring the receive path that feeds task inputs.

---
 rtl/uart_pkg.sv | 23 ++
 rtl/task_tx_fifo.sv | 64 ++++++
 rtl/task_stream_uart_tx.sv | 184 ++++++++++++++++++
 tb/tb_task_stream_uart_tx.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: types, constants and helpers shared by the UART transmit path.
// The PARITY state exists in every build. It is only reachable when
// TASK_TX_PARITY_EN is defined.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

    localparam logic UART_IDLE_LEVEL  = 1'b1;
    localparam logic UART_START_LEVEL = 1'b0;

    // Clock cycles per UART bit. The division truncates, and the caller must
    // keep the result at 2 or more.
    function automatic int clks_per_bit(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/task_tx_fifo.sv
// task_tx_fifo: synchronous FIFO that buffers {last, data} entries for the
// UART transmitter.
// - Full and empty are decoded from the registered occupancy count.
// - A write while full is dropped, even if a read happens in the same cycle.
// - There is no write-to-read bypass: a written entry becomes visible one
//   cycle later.
module task_tx_fifo #(
    parameter int  WIDTH = 9,
    parameter int  DEPTH = 16,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_wr;
    logic             do_rd;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_wr   = wr_en & ~full;
    assign do_rd   = rd_en & ~empty;
    assign rd_data = mem[rd_ptr];

    // Pointer and occupancy bookkeeping; pointers wrap naturally (DEPTH is 2^n)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_wr, do_rd})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage array; contents are only meaningful behind the pointers, so no reset
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr] <= wr_data;
        end
    end

endmodule

// File: rtl/task_stream_uart_tx.sv
// task_stream_uart_tx: buffers a task's unthrottled byte stream and
// serializes each byte as a UART frame on o_tx (LSB first).
// - Default framing is 8N1.
// - Defining TASK_TX_PARITY_EN inserts an even-parity bit, giving 8E1.
// - Consecutive buffered bytes go out as back-to-back frames with no idle gap.
// - o_frame_done marks the final stop-bit cycle of a byte tagged i_last.
module task_stream_uart_tx
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int CLK_FREQ_HZ = 100_000_000,
    parameter int BAUD        = 115200,
    parameter int FIFO_DEPTH  = 16
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_valid,
    input  logic                  i_last,
    output logic                  o_tx,
    output logic                  o_busy,
    output logic                  o_overflow,
    output logic                  o_frame_done
);

    localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ_HZ, BAUD);
    localparam int BAUD_W       = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BIT_W        = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam int CNT_W        = $clog2(FIFO_DEPTH) + 1;

    localparam logic [BAUD_W-1:0] BAUD_RELOAD = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  LAST_BIT    = BIT_W'(DATA_WIDTH - 1);

    tx_state_t             state;
    logic [BAUD_W-1:0]     baud_cnt;
    logic [BIT_W-1:0]      bit_cnt;
    logic [DATA_WIDTH-1:0] shift;
    logic                  last_flag;
`ifdef TASK_TX_PARITY_EN
    logic                  parity_bit;
`endif

    logic [DATA_WIDTH:0]   fifo_rd_data;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [CNT_W-1:0]      fifo_count;
    logic                  bit_end;
    logic                  pop;

    task_tx_fifo #(
        .WIDTH (DATA_WIDTH + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (i_clk),
        .rst     (i_rst),
        .wr_en   (i_valid),
        .wr_data ({i_last, i_data}),
        .rd_en   (pop),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    // A bit period ends when the down-counter reaches zero.
    assign bit_end = (baud_cnt == '0);

    // Pop when idle, or at the end of a stop bit so the next frame starts
    // immediately.
    assign pop = ~fifo_empty & ((state == IDLE) | ((state == STOP) & bit_end));

    // Busy while a frame is on the line or bytes are still buffered.
    assign o_busy = (state != IDLE) | (fifo_count != '0);

    // Character shift register (plus parity): loaded on pop, shifted right as
    // each data bit completes
    always_ff @(posedge i_clk) begin
        if (pop) begin
            shift      <= fifo_rd_data[DATA_WIDTH-1:0];
`ifdef TASK_TX_PARITY_EN
            parity_bit <= ^fifo_rd_data[DATA_WIDTH-1:0];
`endif
        end else if ((state == DATA) && bit_end) begin
            shift <= shift >> 1;
        end
    end

    // Transmit FSM with baud/bit counters; o_tx and o_frame_done are registered
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state        <= IDLE;
            baud_cnt     <= '0;
            bit_cnt      <= '0;
            last_flag    <= 1'b0;
            o_tx         <= UART_IDLE_LEVEL;
            o_frame_done <= 1'b0;
        end else begin
            o_frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    o_tx <= UART_IDLE_LEVEL;
                    if (pop) begin
                        state     <= START;
                        baud_cnt  <= BAUD_RELOAD;
                        last_flag <= fifo_rd_data[DATA_WIDTH];
                        o_tx      <= UART_START_LEVEL;
                    end
                end
                START: begin
                    if (bit_end) begin
                        state    <= DATA;
                        baud_cnt <= BAUD_RELOAD;
                        bit_cnt  <= '0;
                        o_tx     <= shift[0];
                    end else begin
                        baud_cnt <= baud_cnt - BAUD_W'(1);
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        baud_cnt <= BAUD_RELOAD;
                        if (bit_cnt == LAST_BIT) begin
                            bit_cnt <= '0;
`ifdef TASK_TX_PARITY_EN
                            state   <= PARITY;
                            o_tx    <= parity_bit;
`else
                            state   <= STOP;
                            o_tx    <= UART_IDLE_LEVEL;
`endif
                        end else begin
                            bit_cnt <= bit_cnt + BIT_W'(1);
                            // shift[0] is the bit just finished; shift[1] is next.
                            o_tx    <= shift[1];
                        end
                    end else begin
                        baud_cnt <= baud_cnt - BAUD_W'(1);
                    end
                end
                PARITY: begin
                    if (bit_end) begin
                        state    <= STOP;
                        baud_cnt <= BAUD_RELOAD;
                        o_tx     <= UART_IDLE_LEVEL;
                    end else begin
                        baud_cnt <= baud_cnt - BAUD_W'(1);
                    end
                end
                STOP: begin
                    // Raise the pulse one count early so it lands on the final stop cycle.
                    if (baud_cnt == BAUD_W'(1)) begin
                        o_frame_done <= last_flag;
                    end
                    if (bit_end) begin
                        if (pop) begin
                            state     <= START;
                            baud_cnt  <= BAUD_RELOAD;
                            last_flag <= fifo_rd_data[DATA_WIDTH];
                            o_tx      <= UART_START_LEVEL;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        baud_cnt <= baud_cnt - BAUD_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    o_tx  <= UART_IDLE_LEVEL;
                end
            endcase
        end
    end

    // Sticky overflow: a valid byte that meets a full FIFO is lost
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_overflow <= 1'b0;
        end else if (i_valid && fifo_full) begin
            o_overflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_task_stream_uart_tx.sv
// tb_task_stream_uart_tx: table-driven bench with a scoreboard and a
// line monitor.
// - Each accepted byte pushes {data, last, parity} into a queue.
// - The monitor decodes every frame on the TX line and compares it against
//   the queue.
// - Define TASK_TX_PARITY_EN for the 8E1 build.
module tb_task_stream_uart_tx;

    localparam int CPB = 10;  // 1 MHz / 100 kBd
`ifdef TASK_TX_PARITY_EN
    localparam int NSLOT = 11;
`else
    localparam int NSLOT = 10;
`endif
    localparam int FL = NSLOT * CPB;

    typedef struct packed {
        logic [7:0] data;
        logic       last;
        logic       par;
    } exp_t;

    typedef struct {
        logic [7:0] data;
        logic       last;
        logic       par;
    } tvec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] data;
    logic       valid;
    logic       last;
    logic       tx;
    logic       busy;
    logic       overflow;
    logic       frame_done;

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   fd_count = 0;
    int   fd_last_cyc = -1;
    exp_t sb[$];

    logic mon_line [FL];
    logic mon_fd   [FL];
    logic mon_abort;

    task_stream_uart_tx #(
        .DATA_WIDTH  (8),
        .CLK_FREQ_HZ (1_000_000),
        .BAUD        (100_000),
        .FIFO_DEPTH  (16)
    ) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_data       (data),
        .i_valid      (valid),
        .i_last       (last),
        .o_tx         (tx),
        .o_busy       (busy),
        .o_overflow   (overflow),
        .o_frame_done (frame_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (frame_done === 1'b1) begin
            fd_count++;
            fd_last_cyc = cyc;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_frame();
        exp_t       e;
        logic [7:0] got;
        logic       frame_ok;
        logic       fd_ok;
        frame_ok = 1'b1;
        fd_ok    = 1'b1;
        for (int s = 0; s < NSLOT; s++)
            for (int k = 1; k < CPB; k++)
                if (mon_line[s*CPB+k] !== mon_line[s*CPB]) frame_ok = 1'b0;
        if (mon_line[0] !== 1'b0) frame_ok = 1'b0;
        if (mon_line[(NSLOT-1)*CPB] !== 1'b1) frame_ok = 1'b0;
        for (int k = 0; k < 8; k++) got[k] = mon_line[(k+1)*CPB + CPB/2];
        for (int i = 0; i < FL - 1; i++)
            if (mon_fd[i] !== 1'b0) fd_ok = 1'b0;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_frame: got byte %0h, expected no frame (cycle %0d)", got, cyc);
        end else begin
            e = sb.pop_front();
            check("rx_data", {24'd0, got}, {24'd0, e.data});
            check("framing", {31'd0, frame_ok}, 32'd1);
            check("frame_done_pulse", {30'd0, fd_ok, mon_fd[FL-1]}, {30'd0, 1'b1, e.last});
`ifdef TASK_TX_PARITY_EN
            check("rx_parity", {31'd0, mon_line[9*CPB + CPB/2]}, {31'd0, e.par});
`endif
        end
    endtask

    // Line monitor: capture every frame cycle-by-cycle; abandon on reset
    always begin
        @(negedge clk);
        if (rst === 1'b0 && tx === 1'b0) begin
            mon_abort   = 1'b0;
            mon_line[0] = tx;
            mon_fd[0]   = frame_done;
            for (int i = 1; i < FL; i++) begin
                @(negedge clk);
                if (rst !== 1'b0) begin
                    mon_abort = 1'b1;
                    break;
                end
                mon_line[i] = tx;
                mon_fd[i]   = frame_done;
            end
            if (!mon_abort) check_frame();
        end
    end

    // End at the negedge of cycle c (requires cyc <= c on entry).
    task automatic at_neg(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
        @(negedge clk);
    endtask

    // Drive one byte for one cycle; c0 is the cycle in which valid is high.
    task automatic send(input logic [7:0] d, input logic l, input logic push, output int c0);
        exp_t e;
        @(posedge clk);
        #1;
        c0    = cyc;
        data  = d;
        last  = l;
        valid = 1'b1;
        e.data = d;
        e.last = l;
        e.par  = ^d;
        if (push) sb.push_back(e);
        @(posedge clk);
        #1;
        valid = 1'b0;
        last  = 1'b0;
    endtask

    // Wait (bounded) until the DUT is idle and every expected frame was seen.
    task automatic wait_idle(input string name, input int budget);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((busy !== 1'b0 || sb.size() != 0) && n < budget);
        @(negedge clk);
        check({name, "_drained"}, {31'd0, (n < budget)}, 32'd1);
        check({name, "_sb_empty"}, sb.size(), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        tvec_t tv [7];
        int    c0;
        int    s;
        int    fd0;
        int    bad;
        exp_t  e;

        tv[0] = '{8'hA5, 1'b1, 1'b0};
        tv[1] = '{8'h00, 1'b1, 1'b0};
        tv[2] = '{8'hFF, 1'b0, 1'b0};
        tv[3] = '{8'h07, 1'b1, 1'b1};
        tv[4] = '{8'h03, 1'b1, 1'b0};
        tv[5] = '{8'h80, 1'b0, 1'b1};
        tv[6] = '{8'h01, 1'b1, 1'b1};

        rst   = 1'b1;
        valid = 1'b0;
        data  = 8'h00;
        last  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_tx", {31'd0, tx}, 32'd1);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_overflow", {31'd0, overflow}, 32'd0);
        check("reset_frame_done", {31'd0, frame_done}, 32'd0);
        rst = 1'b0;

        // Idle: line must stay high and not busy with no input.
        bad = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0) bad++;
        end
        check("idle_1000_cycles", bad, 32'd0);

        // Single byte 0xA5 with last: start at N+2, pulse at N+1+FL, idle at N+2+FL.
        send(8'hA5, 1'b1, 1'b1, c0);
        at_neg(c0 + 1);
        check("single_tx_before_start", {31'd0, tx}, 32'd1);
        check("single_busy_buffered", {31'd0, busy}, 32'd1);
        at_neg(c0 + 2);
        check("single_start_low", {31'd0, tx}, 32'd0);
        at_neg(c0 + 11);
        check("single_start_end_low", {31'd0, tx}, 32'd0);
        at_neg(c0 + 12);
        check("single_bit0", {31'd0, tx}, 32'd1);
        at_neg(c0 + FL);
        check("single_fd_early", {31'd0, frame_done}, 32'd0);
        at_neg(c0 + 1 + FL);
        check("single_fd_cycle", {31'd0, frame_done}, 32'd1);
        check("single_busy_last_stop", {31'd0, busy}, 32'd1);
        at_neg(c0 + 2 + FL);
        check("single_busy_drop", {31'd0, busy}, 32'd0);
        check("single_fd_one_cycle", {31'd0, frame_done}, 32'd0);
        @(posedge clk);
        #1;
        wait_idle("single", 100);

        // Table of single-byte vectors.
        for (int i = 0; i < 7; i++) begin
            fd0 = fd_count;
            send(tv[i].data, tv[i].last, 1'b1, c0);
            wait_idle($sformatf("vec%0d", i), 300);
            check($sformatf("vec%0d_fd_count", i), fd_count - fd0, {31'd0, tv[i].last});
        end

        // Burst 0x01,0x02,0x03 on consecutive cycles: contiguous frames, one pulse.
        fd0 = fd_count;
        @(posedge clk);
        #1;
        c0 = cyc;
        for (int i = 0; i < 3; i++) begin
            data   = 8'(i + 1);
            last   = (i == 2);
            valid  = 1'b1;
            e.data = 8'(i + 1);
            e.last = (i == 2);
            e.par  = ^e.data;
            sb.push_back(e);
            @(posedge clk);
            #1;
        end
        valid = 1'b0;
        last  = 1'b0;
        at_neg(c0 + 1 + FL);
        check("burst_stop1_high", {31'd0, tx}, 32'd1);
        at_neg(c0 + 2 + FL);
        check("burst_start2_no_gap", {31'd0, tx}, 32'd0);
        at_neg(c0 + 1 + 2*FL);
        check("burst_stop2_high", {31'd0, tx}, 32'd1);
        at_neg(c0 + 2 + 2*FL);
        check("burst_start3_no_gap", {31'd0, tx}, 32'd0);
        @(posedge clk);
        #1;
        wait_idle("burst", 600);
        check("burst_fd_count", fd_count - fd0, 32'd1);
        check("burst_fd_cycle", fd_last_cyc, c0 + 1 + 3*FL);

        // Overflow: 20 bytes on consecutive cycles into a 16-deep FIFO.
        // Byte 0 is popped the cycle after it lands, so bytes 0..16 are
        // accepted (1 in flight + 16 stored) and bytes 17..19 are dropped.
        fd0 = fd_count;
        @(posedge clk);
        #1;
        c0 = cyc;
        for (int i = 0; i < 20; i++) begin
            data  = 8'h40 + 8'(i);
            last  = (i == 16);
            valid = 1'b1;
            if (i < 17) begin
                e.data = 8'h40 + 8'(i);
                e.last = (i == 16);
                e.par  = ^e.data;
                sb.push_back(e);
            end
            @(negedge clk);
            if (i == 17) check("ovf_clear_before_drop", {31'd0, overflow}, 32'd0);
            if (i == 18) check("ovf_set_after_drop", {31'd0, overflow}, 32'd1);
            @(posedge clk);
            #1;
        end
        valid = 1'b0;
        last  = 1'b0;
        wait_idle("overflow", 17*FL + 200);
        check("ovf_sticky", {31'd0, overflow}, 32'd1);
        check("ovf_fd_count", fd_count - fd0, 32'd1);

        // Reset during DATA bit 4 of 0xA5 (bit 4 is 0, so the line is low).
        send(8'hA5, 1'b1, 1'b1, c0);
        s = c0 + 2;
        while (cyc < s + 5*CPB + 5) begin
            @(posedge clk);
            #1;
        end
        check("midframe_tx_low", {31'd0, tx}, 32'd0);
        check("midframe_ovf_held", {31'd0, overflow}, 32'd1);
        rst = 1'b1;
        #1;
        check("midrst_tx", {31'd0, tx}, 32'd1);
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_overflow", {31'd0, overflow}, 32'd0);
        check("midrst_frame_done", {31'd0, frame_done}, 32'd0);
        sb.delete();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        fd0 = fd_count;
        send(8'h3C, 1'b1, 1'b1, c0);
        wait_idle("post_reset", 300);
        check("post_reset_fd_count", fd_count - fd0, 32'd1);
        check("post_reset_overflow", {31'd0, overflow}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
